// File: rtl/bsg_wormhole_adapter_pkg.sv
// Shared types and sizing helpers for the multi-channel wormhole egress adapter.
package bsg_wormhole_adapter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StBody,
        StDrop,
        StFull
    } adapter_state_e;

    // Number of link flits needed to carry a full packet.
    function automatic int unsigned max_flits(input int unsigned packet_width,
                                              input int unsigned flit_width);
        return (packet_width + flit_width - 1) / flit_width;
    endfunction

    // Channel index width; a single channel still gets a 1-bit (always zero) index.
    function automatic int unsigned chan_width(input int unsigned num_chan);
        return (num_chan > 1) ? $clog2(num_chan) : 1;
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: the pointer names the highest-priority requester and
// moves to one past the winner whenever a grant is accepted.
module bsg_arb_round_robin #(
    parameter int unsigned width_p     = 2,
    parameter int unsigned idx_width_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     reqs_i,
    output logic [idx_width_p-1:0] grant_idx_o,
    output logic                   grant_v_o,
    input  logic                   yumi_i
);

    logic [idx_width_p-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_v_o   = 1'b0;
        grant_idx_o = '0;
        for (int unsigned k = 0; k < width_p; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= width_p) begin
                idx = idx - width_p;
            end
            if (!grant_v_o && reqs_i[idx]) begin
                grant_v_o   = 1'b1;
                grant_idx_o = idx_width_p'(idx);
            end
        end
    end

    always_comb begin
        int unsigned nxt;
        nxt = 32'(grant_idx_o) + 1;
        if (nxt >= width_p) begin
            nxt = 0;
        end
        ptr_d = (yumi_i && grant_v_o) ? idx_width_p'(nxt) : ptr_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bsg_wormhole_router_adapter_out_mc.sv
// Multi-channel wormhole deserializer: arbitrates whole packets from several links,
// reassembles them into one wide register and drops packets whose header is oversize.
module bsg_wormhole_router_adapter_out_mc
    import bsg_wormhole_adapter_pkg::*;
#(
    parameter int unsigned max_payload_width_p = 40,
    parameter int unsigned len_width_p         = 4,
    parameter int unsigned cord_width_p        = 4,
    parameter int unsigned flit_width_p        = 16,
    parameter int unsigned num_in_p            = 2,
    parameter int unsigned drop_cnt_width_p    = 8
) (
    input  logic                                                   clk_i,
    input  logic                                                   reset_i,
    input  logic [num_in_p-1:0]                                    link_v_i,
    input  logic [num_in_p*flit_width_p-1:0]                       link_data_i,
    output logic [num_in_p-1:0]                                    link_ready_and_o,
    output logic [cord_width_p+len_width_p+max_payload_width_p-1:0] packet_o,
    output logic [chan_width(num_in_p)-1:0]                        packet_chan_o,
    output logic                                                   packet_v_o,
    input  logic                                                   packet_yumi_i,
    output logic                                                   err_v_o,
    output logic [chan_width(num_in_p)-1:0]                        err_chan_o,
    output logic [drop_cnt_width_p-1:0]                            drop_cnt_o
);

    localparam int unsigned PacketW  = cord_width_p + len_width_p + max_payload_width_p;
    localparam int unsigned MaxFlits = max_flits(PacketW, flit_width_p);
    localparam int unsigned ChanW    = chan_width(num_in_p);
    localparam int unsigned SlotW    = MaxFlits * flit_width_p;

    adapter_state_e state_q, state_d;

    logic [ChanW-1:0]            chan_q;
    logic [len_width_p-1:0]      len_q;
    // Next slot index while in BODY, flits still to discard while in DROP.
    logic [len_width_p-1:0]      cnt_q;
    logic                        err_q;
    logic [ChanW-1:0]            err_chan_q;
    logic [drop_cnt_width_p-1:0] drop_cnt_q;

    logic [flit_width_p-1:0]     slot_q [MaxFlits];
    logic [MaxFlits-1:0]         slot_we;
    logic                        slot_clr;
    logic [SlotW-1:0]            slots_flat;

    logic                        in_link;
    logic                        v_sel;
    logic                        xfer;
    logic [flit_width_p-1:0]     flit_sel;
    logic [len_width_p-1:0]      hdr_len;
    logic                        oversize;

    logic [ChanW-1:0]            grant_idx;
    logic                        grant_v;
    logic                        arb_yumi;

    bsg_arb_round_robin #(
        .width_p     (num_in_p),
        .idx_width_p (ChanW)
    ) u_arb (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .reqs_i      (link_v_i),
        .grant_idx_o (grant_idx),
        .grant_v_o   (grant_v),
        .yumi_i      (arb_yumi)
    );

    assign in_link  = (state_q == StHdr) || (state_q == StBody) || (state_q == StDrop);
    assign flit_sel = link_data_i[32'(chan_q)*flit_width_p +: flit_width_p];
    assign v_sel    = link_v_i[chan_q];
    assign xfer     = in_link && v_sel;
    assign hdr_len  = flit_sel[cord_width_p +: len_width_p];
    assign oversize = 32'(hdr_len) > (MaxFlits - 1);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_v) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (xfer) begin
                    if (oversize) begin
                        state_d = StDrop;
                    end else if (hdr_len == '0) begin
                        state_d = StFull;
                    end else begin
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (xfer && (cnt_q == len_q)) begin
                    state_d = StFull;
                end
            end
            StDrop: begin
                if (xfer && (cnt_q == len_width_p'(1))) begin
                    state_d = StIdle;
                end
            end
            StFull: begin
                if (packet_yumi_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        link_ready_and_o = '0;
        for (int unsigned c = 0; c < num_in_p; c++) begin
            link_ready_and_o[c] = in_link && (32'(chan_q) == c);
        end
        packet_v_o = (state_q == StFull);
        arb_yumi   = (state_q == StIdle) && grant_v;
        slot_clr   = arb_yumi;
        for (int unsigned i = 0; i < MaxFlits; i++) begin
            slot_we[i] = xfer && (((state_q == StHdr) && (i == 0))
                               || ((state_q == StBody) && (32'(cnt_q) == i)));
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chan_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_chan_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (arb_yumi) begin
                chan_q <= grant_idx;
            end
            if ((state_q == StHdr) && xfer) begin
                len_q <= hdr_len;
                if (oversize) begin
                    cnt_q      <= hdr_len;
                    err_q      <= 1'b1;
                    err_chan_q <= chan_q;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_q <= drop_cnt_q + drop_cnt_width_p'(1);
                    end
                end else begin
                    cnt_q <= len_width_p'(1);
                end
            end
            if ((state_q == StBody) && xfer) begin
                cnt_q <= cnt_q + len_width_p'(1);
            end
            if ((state_q == StDrop) && xfer) begin
                cnt_q <= cnt_q - len_width_p'(1);
            end
        end
    end

    // Slots are zeroed on every new grant so short packets leave high slots at zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < MaxFlits; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MaxFlits; i++) begin
                if (slot_clr) begin
                    slot_q[i] <= '0;
                end else if (slot_we[i]) begin
                    slot_q[i] <= flit_sel;
                end
            end
        end
    end

    always_comb begin
        slots_flat = '0;
        for (int unsigned i = 0; i < MaxFlits; i++) begin
            slots_flat[i*flit_width_p +: flit_width_p] = slot_q[i];
        end
    end

    assign packet_o      = slots_flat[PacketW-1:0];
    assign packet_chan_o = chan_q;
    assign err_v_o       = err_q;
    assign err_chan_o    = err_chan_q;
    assign drop_cnt_o    = drop_cnt_q;

    yumi_only_when_full: assert property (
        @(posedge clk_i) disable iff (reset_i) packet_yumi_i |-> (state_q == StFull)
    );

endmodule

// File: tb/tb_bsg_wormhole_router_adapter_out_mc.sv
// Self-checking bench: per-channel flit queues drive the links, a scoreboard holds
// expected packets, and each scenario task compares what the adapter delivers.
module tb_bsg_wormhole_router_adapter_out_mc;

    localparam int FW = 16;

    typedef struct packed {
        logic [47:0] p;
        logic        c;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  link_v;
    logic [31:0] link_data;
    logic [1:0]  link_ready;
    logic [47:0] packet;
    logic [0:0]  packet_chan;
    logic        packet_v;
    logic        packet_yumi;
    logic        err_v;
    logic [0:0]  err_chan;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] fq0[$];
    logic [15:0] fq1[$];
    exp_t        sb[$];

    logic [1:0] fire;
    int cyc = 0;
    int fire_cnt[2];
    int last_fire_cyc[2];
    int pv_rises = 0;
    int pv_rise_cyc = 0;
    logic pv_prev = 1'b0;
    logic err_prev = 1'b0;
    int err_pulses = 0;
    int err_hi = 0;
    logic err_last_chan = 1'b0;

    bsg_wormhole_router_adapter_out_mc #(
        .max_payload_width_p (40),
        .len_width_p         (4),
        .cord_width_p        (4),
        .flit_width_p        (16),
        .num_in_p            (2),
        .drop_cnt_width_p    (8)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .link_v_i         (link_v),
        .link_data_i      (link_data),
        .link_ready_and_o (link_ready),
        .packet_o         (packet),
        .packet_chan_o    (packet_chan),
        .packet_v_o       (packet_v),
        .packet_yumi_i    (packet_yumi),
        .err_v_o          (err_v),
        .err_chan_o       (err_chan),
        .drop_cnt_o       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Handshake inputs are stable from one posedge+1 to the next posedge.
    always @(negedge clk) fire = link_v & link_ready;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (reset) begin
            link_v    = 2'b00;
            link_data = '0;
        end else begin
            if (fire[0]) begin
                void'(fq0.pop_front());
                fire_cnt[0]      = fire_cnt[0] + 1;
                last_fire_cyc[0] = cyc;
            end
            if (fire[1]) begin
                void'(fq1.pop_front());
                fire_cnt[1]      = fire_cnt[1] + 1;
                last_fire_cyc[1] = cyc;
            end
            link_v[0]        = (fq0.size() > 0);
            link_v[1]        = (fq1.size() > 0);
            link_data[15:0]  = (fq0.size() > 0) ? fq0[0] : 16'h0;
            link_data[31:16] = (fq1.size() > 0) ? fq1[0] : 16'h0;
        end
        fire = 2'b00;
        if (packet_v && !pv_prev) begin
            pv_rises    = pv_rises + 1;
            pv_rise_cyc = cyc;
        end
        pv_prev = packet_v;
        if (err_v) begin
            err_hi        = err_hi + 1;
            err_last_chan = err_chan[0];
            if (!err_prev) err_pulses = err_pulses + 1;
        end
        err_prev = err_v;
    end

    task automatic push_flit(input int c, input logic [15:0] f);
        if (c == 0) fq0.push_back(f);
        else        fq1.push_back(f);
    endtask

    // Queue the flits of one packet; legal packets also go onto the scoreboard.
    task automatic send_pkt(input int c, input int len, input logic [3:0] cord,
                            input logic [39:0] payload);
        logic [47:0] full;
        exp_t e;
        full = {payload, len[3:0], cord};
        for (int i = 0; i <= len; i++) begin
            if (i < 3) push_flit(c, full[i*FW +: FW]);
            else       push_flit(c, 16'($urandom));
        end
        if (len <= 2) begin
            e.p = full;
            for (int i = len + 1; i < 3; i++) e.p[i*FW +: FW] = 16'h0;
            e.c = c[0];
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) for a packet, capture it, then accept it with a one-cycle yumi.
    task automatic get_pkt(output logic ok, output logic [47:0] p, output logic c);
        ok = 1'b0;
        p  = '0;
        c  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (packet_v) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            p           = packet;
            c           = packet_chan[0];
            packet_yumi = 1'b1;
            @(negedge clk);
            packet_yumi = 1'b0;
        end
    endtask

    task automatic wait_fires(input int c, input int target, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (fire_cnt[c] >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        fq0.delete();
        fq1.delete();
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (packet_v !== 1'b0 || packet !== 48'h0 || packet_chan !== 1'b0 || err_v !== 1'b0
            || err_chan !== 1'b0 || drop_cnt !== 8'h0 || link_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: v=%b pkt=%h chan=%b err=%b ec=%b drop=%h rdy=%b want all 0",
                     packet_v, packet, packet_chan, err_v, err_chan, drop_cnt, link_ready);
        end
    endtask

    task automatic test_basic();
        logic ok;
        logic [47:0] p;
        logic c;
        exp_t e;
        send_pkt(0, 2, 4'h0, 40'hCCCC_BBBB_1A);
        get_pkt(ok, p, c);
        e = sb.pop_front();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_timeout: packet_v_o never rose, want a packet");
        end else begin
            if (p !== e.p || p !== 48'hCCCC_BBBB_1A20) begin
                failures++;
                $display("FAIL basic_packet: got %h want %h", p, 48'hCCCC_BBBB_1A20);
            end
            checks++;
            if (c !== 1'b0) begin
                failures++;
                $display("FAIL basic_chan: got %b want 0", c);
            end
            checks++;
            if (pv_rise_cyc !== last_fire_cyc[0]) begin
                failures++;
                $display("FAIL basic_latency: valid rose at edge %0d want edge %0d",
                         pv_rise_cyc, last_fire_cyc[0]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic ok;
        logic [47:0] p;
        logic c;
        exp_t e;
        int n0 = 0;
        int n1 = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            send_pkt(0, 0, 4'(i), 40'($urandom));
            send_pkt(1, 0, 4'(i + 8), 40'($urandom));
        end
        for (int i = 0; i < 10; i++) begin
            get_pkt(ok, p, c);
            e = sb.pop_front();
            checks++;
            if (!ok || p !== e.p || c !== e.c) begin
                failures++;
                $display("FAIL rr_packet_%0d: ok=%b got %h ch%b want %h ch%b",
                         i, ok, p, c, e.p, e.c);
            end
            if (ok && c) n1++;
            else if (ok) n0++;
        end
        checks++;
        if (n0 !== 5 || n1 !== 5) begin
            failures++;
            $display("FAIL rr_split: got %0d/%0d want 5/5", n0, n1);
        end
    endtask

    task automatic test_oversize();
        logic ok;
        logic [47:0] p;
        logic c;
        exp_t e;
        int f_base  = fire_cnt[1];
        int ep_base = err_pulses;
        int eh_base = err_hi;
        int pv_base = pv_rises;
        send_pkt(1, 5, 4'h3, 40'($urandom));
        wait_fires(1, f_base + 6, ok);
        repeat (4) @(negedge clk);
        checks++;
        if (!ok || fire_cnt[1] - f_base !== 6) begin
            failures++;
            $display("FAIL drop_flits: consumed %0d want 6", fire_cnt[1] - f_base);
        end
        checks++;
        if (err_pulses - ep_base !== 1 || err_hi - eh_base !== 1 || err_last_chan !== 1'b1) begin
            failures++;
            $display("FAIL drop_err: pulses=%0d hi=%0d chan=%b want 1 1 1",
                     err_pulses - ep_base, err_hi - eh_base, err_last_chan);
        end
        checks++;
        if (drop_cnt !== 8'd1) begin
            failures++;
            $display("FAIL drop_cnt: got %0d want 1", drop_cnt);
        end
        checks++;
        if (pv_rises !== pv_base) begin
            failures++;
            $display("FAIL drop_no_valid: %0d valid rises want 0", pv_rises - pv_base);
        end
        send_pkt(0, 2, 4'h5, 40'($urandom));
        get_pkt(ok, p, c);
        e = sb.pop_front();
        checks++;
        if (!ok || p !== e.p || c !== e.c) begin
            failures++;
            $display("FAIL drop_next_packet: ok=%b got %h ch%b want %h ch%b",
                     ok, p, c, e.p, e.c);
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        logic [47:0] p;
        logic c;
        exp_t e;
        logic bad;
        apply_reset();
        send_pkt(0, 1, 4'h1, 40'($urandom));
        send_pkt(1, 2, 4'h2, 40'($urandom));
        send_pkt(0, 0, 4'h3, 40'($urandom));
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (packet_v) begin
                ok = 1'b1;
                break;
            end
        end
        e   = sb.pop_front();
        bad = !ok;
        for (int i = 0; i < 20; i++) begin
            if (packet !== e.p || packet_chan !== e.c || packet_v !== 1'b1
                || link_ready !== 2'b00 || link_v !== 2'b11) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL hold_stable: pkt=%h ch%b v=%b rdy=%b lv=%b want %h ch%b v=1 rdy=00 lv=11",
                     packet, packet_chan, packet_v, link_ready, link_v, e.p, e.c);
        end
        for (int i = 0; i < 3; i++) begin
            get_pkt(ok, p, c);
            if (i > 0) e = sb.pop_front();
            checks++;
            if (!ok || p !== e.p || c !== e.c) begin
                failures++;
                $display("FAIL hold_packet_%0d: ok=%b got %h ch%b want %h ch%b",
                         i, ok, p, c, e.p, e.c);
            end
        end
    endtask

    task automatic test_reset_mid_body();
        logic ok;
        logic [47:0] p;
        logic c;
        exp_t e;
        int base = fire_cnt[0];
        push_flit(0, 16'h9A20);
        push_flit(0, 16'h1234);
        wait_fires(0, base + 2, ok);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (!ok || packet_v !== 1'b0 || packet !== 48'h0 || link_ready !== 2'b00
            || drop_cnt !== 8'h0 || err_v !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_body: ok=%b v=%b pkt=%h rdy=%b drop=%h err=%b want all 0",
                     ok, packet_v, packet, link_ready, drop_cnt, err_v);
        end
        fq0.delete();
        fq1.delete();
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_pkt(0, 2, 4'h7, 40'($urandom));
        get_pkt(ok, p, c);
        e = sb.pop_front();
        checks++;
        if (!ok || p !== e.p || c !== e.c) begin
            failures++;
            $display("FAIL reset_fresh_packet: ok=%b got %h ch%b want %h ch%b",
                     ok, p, c, e.p, e.c);
        end
    endtask

    task automatic test_drop_saturate();
        logic ok;
        int flits   = 0;
        int base    = fire_cnt[1];
        int ep_base = err_pulses;
        for (int i = 0; i < 255; i++) begin
            send_pkt(1, 3 + (i % 4), 4'(i), 40'($urandom));
            flits += 4 + (i % 4);
        end
        wait_fires(1, base + flits, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || drop_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL drop_255: ok=%b got %h want ff", ok, drop_cnt);
        end
        send_pkt(1, 3, 4'h0, 40'($urandom));
        flits += 4;
        wait_fires(1, base + flits, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || drop_cnt !== 8'hFF || err_pulses - ep_base !== 256) begin
            failures++;
            $display("FAIL drop_saturate: ok=%b cnt=%h pulses=%0d want ff 256",
                     ok, drop_cnt, err_pulses - ep_base);
        end
    endtask

    initial begin
        reset       = 1'b1;
        link_v      = 2'b00;
        link_data   = '0;
        packet_yumi = 1'b0;
        fire        = 2'b00;
        fire_cnt[0] = 0;
        fire_cnt[1] = 0;
        last_fire_cyc[0] = 0;
        last_fire_cyc[1] = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_oversize();
        test_backpressure();
        test_reset_mid_body();
        test_drop_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
